packet_capture: RTL
===================

// Module: packet_capture
// PURPOSE
//  Downstream stage of the A5A5A5A5 sync-word detector. When the detector raises newpacket,
//  this block deserialises the 1-bit stream that follows the sync word: an 8-bit length
//  header, LEN payload bytes, then an 8-bit XOR checksum. Payload bytes stream out one at a
//  time; the block then pulses done back to the detector to re-arm sync search.
// PARAMETERS
//  MAX_LEN   64  largest accepted payload length in bytes (1..255); larger header = error
//  CKSUM_EN  1   1: verify trailer checksum; 0: trailer byte still consumed, never checked
// PORTS
//  clk         in   1  clock
//  rst_n       in   1  reset, synchronous, active-low
//  data        in   1  serial bit stream, same signal feeding the detector, MSB first
//  newpacket   in   1  from detector; level, held high until done is seen
//  done        out  1  to detector; capture finished (normal or error)
//  byte_out    out  8  payload byte, valid when byte_valid=1
//  byte_valid  out  1  one-cycle strobe per payload byte
//  pkt_len     out  8  header length of current/last packet; held until next header
//  pkt_ok      out  1  one-cycle strobe with done: packet complete, checksum good
//  pkt_err     out  1  one-cycle strobe with done: oversize length or checksum mismatch
//  busy        out  1  high in any state other than IDLE
// BEHAVIOUR
//  Reset: state=IDLE; done, byte_valid, pkt_ok, pkt_err, busy = 0; byte_out, pkt_len = 0x00;
//   bit/byte counters and checksum accumulator cleared. Reset wins over every other event,
//   including mid-packet; no done/strobe emitted for an aborted packet.
//  States: IDLE, HDR, PAYLOAD, CKSUM, DONE.
//  IDLE: newpacket=1 -> the data bit sampled this cycle is header bit7; go HDR (bit cnt=1).
//  HDR: shift 8 bits total. On 8th bit: pkt_len<=hdr, cksum<=hdr.
//   hdr>MAX_LEN -> DONE with err flag; hdr==0 -> CKSUM; else PAYLOAD.
//  PAYLOAD: shift bits MSB first; on each 8th bit: byte_out<=byte, byte_valid=1 next cycle,
//   cksum^=byte, byte cnt++. After byte LEN -> CKSUM.
//  CKSUM: shift 8 bits; on 8th: err = CKSUM_EN && (trailer != cksum); go DONE.
//  DONE: done=1; pkt_ok/pkt_err=1 in the first DONE cycle only. Stay in DONE (done held)
//   until newpacket=0, then IDLE. With a compliant detector done is high exactly 1 cycle.
//  Latency: cycle 0 = first IDLE cycle with newpacket=1. Bits sampled cycles 0..(8*(LEN+2)-1);
//   done/pkt_ok/pkt_err high in cycle 8*(LEN+2). Oversize: done in cycle 8.
//   Payload byte k (0-based) byte_valid in cycle 8*(k+2).
//  newpacket ignored outside IDLE/DONE; newpacket dropping mid-packet does not abort.
//  All outputs registered; byte_valid never coincides with done.
//  Widths: bit counter 3b wraps 7->0; byte counter 8b, compared to pkt_len; cksum 8b XOR.
// TESTING
//  T1 LEN=0x02, payload 3C,C3, trailer FD -> byte_valid cyc16 (3C), cyc24 (C3); done+pkt_ok cyc32.
//  T2 LEN=0x00, trailer 00 -> no byte_valid; done+pkt_ok cyc16; pkt_len=00.
//  T3 LEN=0x80 (MAX_LEN=64) -> no byte_valid; done+pkt_err cyc8; pkt_len=80.
//  T4 T1 with trailer FC -> bytes as T1; done+pkt_err cyc32; with CKSUM_EN=0 -> pkt_ok instead.
//  T5 rst_n=0 during payload byte 1 of T1 -> all outputs 0 next cycle, IDLE, no done;
//   following sync+packet captured normally.
//  T6 newpacket held high (detector stalled) 5 cycles after done -> done stays high 6 cycles,
//   pkt_ok only in first; IDLE after newpacket falls; back-to-back packets both captured.

Source files
------------

// File: rtl/packet_capture.sv
// packet_capture: deserialises a length-prefixed, XOR-checksummed packet that
// follows the sync word. The stream arrives one bit per cycle, MSB first. The
// block emits one strobe per payload byte and a done pulse (with ok/err) at the
// end so the upstream detector can re-arm its sync search.
module packet_capture #(
   parameter int unsigned MAX_LEN  = 64,
   parameter bit          CKSUM_EN = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       data,
   input  logic       newpacket,
   output logic       done,
   output logic [7:0] byte_out,
   output logic       byte_valid,
   output logic [7:0] pkt_len,
   output logic       pkt_ok,
   output logic       pkt_err,
   output logic       busy
);

   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_PAYLOAD,
      ST_CKSUM,
      ST_DONE
   } state_t;

   state_t     state_q, state_d;

   // Bit position inside the current byte; wraps 7 -> 0 so it never needs an
   // explicit clear between bytes.
   logic [2:0] bit_cnt_q, bit_cnt_d;
   // The seven bits received so far of the current byte; the eighth bit is
   // taken straight from the data input when the byte completes.
   logic [6:0] shift_q, shift_d;
   logic [7:0] byte_cnt_q, byte_cnt_d;
   logic [7:0] cksum_q, cksum_d;

   // Registered outputs
   logic       done_q, done_d;
   logic [7:0] byte_out_q, byte_out_d;
   logic       byte_valid_q, byte_valid_d;
   logic [7:0] pkt_len_q, pkt_len_d;
   logic       pkt_ok_q, pkt_ok_d;
   logic       pkt_err_q, pkt_err_d;
   logic       busy_q, busy_d;

   // Helpers shared by the shifting states
   logic [7:0] byte_now;
   logic       last_bit;
   logic [7:0] byte_cnt_inc;
   logic       trailer_bad;

   assign byte_now     = {shift_q, data};
   assign last_bit     = (bit_cnt_q == 3'd7);
   assign byte_cnt_inc = byte_cnt_q + 8'd1;
   assign trailer_bad  = CKSUM_EN && (byte_now != cksum_q);

   // State and datapath registers; reset aborts any packet without a done.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         bit_cnt_q    <= 3'd0;
         shift_q      <= 7'd0;
         byte_cnt_q   <= 8'd0;
         cksum_q      <= 8'd0;
         done_q       <= 1'b0;
         byte_out_q   <= 8'd0;
         byte_valid_q <= 1'b0;
         pkt_len_q    <= 8'd0;
         pkt_ok_q     <= 1'b0;
         pkt_err_q    <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         byte_cnt_q   <= byte_cnt_d;
         cksum_q      <= cksum_d;
         done_q       <= done_d;
         byte_out_q   <= byte_out_d;
         byte_valid_q <= byte_valid_d;
         pkt_len_q    <= pkt_len_d;
         pkt_ok_q     <= pkt_ok_d;
         pkt_err_q    <= pkt_err_d;
         busy_q       <= busy_d;
      end
   end

   // Next-state and next-output logic; strobes default low, data outputs hold.
   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      byte_cnt_d   = byte_cnt_q;
      cksum_d      = cksum_q;
      byte_out_d   = byte_out_q;
      pkt_len_d    = pkt_len_q;
      byte_valid_d = 1'b0;
      pkt_ok_d     = 1'b0;
      pkt_err_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            // The bit present in the same cycle as newpacket is header bit 7.
            if (newpacket) begin
               shift_d    = {6'd0, data};
               bit_cnt_d  = 3'd1;
               byte_cnt_d = 8'd0;
               cksum_d    = 8'd0;
               state_d    = ST_HDR;
            end
         end

         ST_HDR: begin
            shift_d   = byte_now[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (last_bit) begin
               pkt_len_d = byte_now;
               cksum_d   = byte_now;
               if (byte_now > MAX_LEN_B) begin
                  // Oversize: skip payload and trailer entirely.
                  pkt_err_d = 1'b1;
                  state_d   = ST_DONE;
               end else if (byte_now == 8'd0) begin
                  state_d = ST_CKSUM;
               end else begin
                  state_d = ST_PAYLOAD;
               end
            end
         end

         ST_PAYLOAD: begin
            shift_d   = byte_now[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (last_bit) begin
               byte_out_d   = byte_now;
               byte_valid_d = 1'b1;
               cksum_d      = cksum_q ^ byte_now;
               byte_cnt_d   = byte_cnt_inc;
               if (byte_cnt_inc == pkt_len_q) begin
                  state_d = ST_CKSUM;
               end
            end
         end

         ST_CKSUM: begin
            // Trailer is always consumed; it is only judged when checking is on.
            shift_d   = byte_now[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (last_bit) begin
               pkt_ok_d  = !trailer_bad;
               pkt_err_d = trailer_bad;
               state_d   = ST_DONE;
            end
         end

         ST_DONE: begin
            // Hold done until the detector lets go of newpacket.
            if (!newpacket) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      done_d = (state_d == ST_DONE);
      busy_d = (state_d != ST_IDLE);
   end

   assign done       = done_q;
   assign byte_out   = byte_out_q;
   assign byte_valid = byte_valid_q;
   assign pkt_len    = pkt_len_q;
   assign pkt_ok     = pkt_ok_q;
   assign pkt_err    = pkt_err_q;
   assign busy       = busy_q;

endmodule
